// File: rtl/tetris_row_driver.sv
// One playfield row: per-cell off/active/fixed state with colour, neighbour
// obstruction checks, and the full-row flash/clear-request sequence.
module tetris_row_driver #(
    parameter int WIDTH       = 8,
    parameter int COLOR_W     = 2,
    parameter int FLASH_TICKS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       grav,
    input  logic                       down_req,
    input  logic                       left_req,
    input  logic                       right_req,
    input  logic                       move_down,
    input  logic                       move_left,
    input  logic                       move_right,
    input  logic [WIDTH-1:0]           activate_mask,
    input  logic [COLOR_W-1:0]         activate_color,
    input  logic [WIDTH-1:0]           off_mask,
    input  logic                       fix,
    input  logic                       destruct,
    input  logic [WIDTH-1:0]           above_active,
    input  logic [WIDTH-1:0]           above_fixed,
    input  logic [WIDTH*COLOR_W-1:0]   above_color,
    input  logic [WIDTH-1:0]           below_fixed,
    output logic [WIDTH-1:0]           active,
    output logic [WIDTH-1:0]           fixed,
    output logic [WIDTH*COLOR_W-1:0]   color,
    output logic [WIDTH-1:0]           disp_fixed,
    output logic                       ok_down,
    output logic                       ok_left,
    output logic                       ok_right,
    output logic                       landed,
    output logic                       clear_req
);

    localparam int CNT_W = $clog2(FLASH_TICKS + 1);

    typedef enum logic [1:0] {
        S_NORMAL,
        S_FLASH,
        S_WAIT
    } row_state_t;

    row_state_t                 state;
    logic [CNT_W-1:0]           cnt;
    logic                       phase;

    logic [WIDTH-1:0]           act_q, fix_q, act_d, fix_d;
    logic [WIDTH*COLOR_W-1:0]   col_q, col_d;

    // Neighbour views: *_r is what cell i sees at i-1, *_l what it sees at i+1.
    logic [WIDTH-1:0]           src_r, src_l;
    logic [WIDTH*COLOR_W-1:0]   col_r, col_l;
    logic [WIDTH-1:0]           blk_left, blk_right;
    logic                       edit_en;
    logic                       unused_reqs;

    assign src_r     = {act_q[WIDTH-2:0], 1'b0};
    assign src_l     = {1'b0, act_q[WIDTH-1:1]};
    assign col_r     = {col_q[(WIDTH-1)*COLOR_W-1:0], {COLOR_W{1'b0}}};
    assign col_l     = {{COLOR_W{1'b0}}, col_q[WIDTH*COLOR_W-1:COLOR_W]};
    assign blk_left  = {fix_q[WIDTH-2:0], 1'b1};
    assign blk_right = {1'b1, fix_q[WIDTH-1:1]};
    assign edit_en   = (state == S_NORMAL);

    // Lateral requests are resolved by the controller from ok_left/ok_right.
    assign unused_reqs = &{1'b0, left_req, right_req};

    always_comb begin
        act_d = act_q;
        fix_d = fix_q;
        col_d = col_q;
        if (destruct) begin
            act_d = '0;
            fix_d = above_fixed;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                col_d[i*COLOR_W +: COLOR_W] = above_fixed[i] ? above_color[i*COLOR_W +: COLOR_W]
                                                             : '0;
            end
        end else if (fix) begin
            fix_d = fix_q | act_q;
            act_d = '0;
        end else if (edit_en) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (activate_mask[i] && !act_q[i] && !fix_q[i]) begin
                    act_d[i]                    = 1'b1;
                    col_d[i*COLOR_W +: COLOR_W] = activate_color;
                end else if (off_mask[i] && act_q[i] && !activate_mask[i]) begin
                    act_d[i] = 1'b0;
                end else if (!fix_q[i]) begin
                    if (move_down) begin
                        act_d[i] = above_active[i];
                        if (above_active[i])
                            col_d[i*COLOR_W +: COLOR_W] = above_color[i*COLOR_W +: COLOR_W];
                    end else if (move_right) begin
                        act_d[i] = src_r[i];
                        if (src_r[i])
                            col_d[i*COLOR_W +: COLOR_W] = col_r[i*COLOR_W +: COLOR_W];
                    end else if (move_left) begin
                        act_d[i] = src_l[i];
                        if (src_l[i])
                            col_d[i*COLOR_W +: COLOR_W] = col_l[i*COLOR_W +: COLOR_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q     <= '0;
            fix_q     <= '0;
            col_q     <= '0;
            state     <= S_NORMAL;
            cnt       <= '0;
            phase     <= 1'b0;
            clear_req <= 1'b0;
        end else begin
            act_q <= act_d;
            fix_q <= fix_d;
            col_q <= col_d;
            if (destruct) begin
                state     <= S_NORMAL;
                cnt       <= '0;
                phase     <= 1'b0;
                clear_req <= 1'b0;
            end else begin
                case (state)
                    S_NORMAL: begin
                        if (&fix_q) begin
                            state <= S_FLASH;
                            cnt   <= '0;
                            phase <= 1'b0;
                        end
                    end
                    S_FLASH: begin
                        if (grav) begin
                            phase <= ~phase;
                            cnt   <= cnt + 1'b1;
                            if (cnt == CNT_W'(FLASH_TICKS - 1)) begin
                                state     <= S_WAIT;
                                clear_req <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        clear_req <= 1'b1;
                    end
                    default: begin
                        state     <= S_NORMAL;
                        cnt       <= '0;
                        phase     <= 1'b0;
                        clear_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign active     = act_q;
    assign fixed      = fix_q;
    assign color      = col_q;
    assign disp_fixed = (state == S_FLASH && phase) ? '0 : fix_q;
    assign ok_down    = ~|(act_q & below_fixed);
    assign ok_left    = ~|(act_q & blk_left);
    assign ok_right   = ~|(act_q & blk_right);
    assign landed     = (grav | down_req) & (|(act_q & below_fixed));

endmodule

// File: tb/tb_tetris_row_driver.sv
// Directed bench for tetris_row_driver: movement, obstruction, landing,
// flash/clear sequence, destruct and reset recovery.
module tb_tetris_row_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        grav, down_req, left_req, right_req;
    logic        move_down, move_left, move_right;
    logic [7:0]  activate_mask;
    logic [1:0]  activate_color;
    logic [7:0]  off_mask;
    logic        fix, destruct;
    logic [7:0]  above_active, above_fixed;
    logic [15:0] above_color;
    logic [7:0]  below_fixed;
    logic [7:0]  active, fixed, disp_fixed;
    logic [15:0] color;
    logic        ok_down, ok_left, ok_right, landed, clear_req;

    int checks = 0;
    int passed = 0;

    tetris_row_driver #(.WIDTH(8), .COLOR_W(2), .FLASH_TICKS(3)) dut (
        .clk(clk), .reset(reset), .grav(grav), .down_req(down_req),
        .left_req(left_req), .right_req(right_req), .move_down(move_down),
        .move_left(move_left), .move_right(move_right),
        .activate_mask(activate_mask), .activate_color(activate_color),
        .off_mask(off_mask), .fix(fix), .destruct(destruct),
        .above_active(above_active), .above_fixed(above_fixed),
        .above_color(above_color), .below_fixed(below_fixed),
        .active(active), .fixed(fixed), .color(color), .disp_fixed(disp_fixed),
        .ok_down(ok_down), .ok_left(ok_left), .ok_right(ok_right),
        .landed(landed), .clear_req(clear_req)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        grav = 0; down_req = 0; left_req = 0; right_req = 0;
        move_down = 0; move_left = 0; move_right = 0;
        activate_mask = '0; activate_color = '0; off_mask = '0;
        fix = 0; destruct = 0;
        above_active = '0; above_fixed = '0; above_color = '0; below_fixed = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic fill_row();
        activate_mask = 8'hFF; activate_color = 2'd1; tick(); idle_inputs();
        fix = 1; tick(); idle_inputs();
    endtask

    task automatic grav_tick();
        grav = 1; tick(); grav = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (active !== 8'h00) $display("FAIL rst_active got %h exp 00", active); else passed++;
        checks++; if (fixed !== 8'h00) $display("FAIL rst_fixed got %h exp 00", fixed); else passed++;
        checks++; if (color !== 16'h0000) $display("FAIL rst_color got %h exp 0000", color); else passed++;
        checks++; if (disp_fixed !== 8'h00) $display("FAIL rst_disp got %h exp 00", disp_fixed); else passed++;
        checks++; if ({ok_down, ok_left, ok_right} !== 3'b111)
            $display("FAIL rst_ok got %b exp 111", {ok_down, ok_left, ok_right}); else passed++;
        checks++; if ({landed, clear_req} !== 2'b00)
            $display("FAIL rst_landed_clr got %b exp 00", {landed, clear_req}); else passed++;
    endtask

    task automatic test_activate();
        do_reset();
        activate_mask = 8'b0001_1000; activate_color = 2'd2; tick(); idle_inputs();
        checks++; if (active !== 8'b0001_1000) $display("FAIL act_active got %b exp 00011000", active); else passed++;
        checks++; if (color !== 16'h0280) $display("FAIL act_color got %h exp 0280", color); else passed++;
        checks++; if ({ok_down, ok_left, ok_right} !== 3'b111)
            $display("FAIL act_ok got %b exp 111", {ok_down, ok_left, ok_right}); else passed++;
    endtask

    task automatic test_obstruction();
        do_reset();
        activate_mask = 8'b0100_0000; tick(); idle_inputs();
        fix = 1; tick(); idle_inputs();
        activate_mask = 8'b1000_0000; tick(); idle_inputs();
        checks++; if (ok_right !== 1'b0) $display("FAIL obs_right got %b exp 0", ok_right); else passed++;
        checks++; if (ok_left !== 1'b0) $display("FAIL obs_left got %b exp 0", ok_left); else passed++;
        checks++; if (ok_down !== 1'b1) $display("FAIL obs_down got %b exp 1", ok_down); else passed++;
    endtask

    task automatic test_moves();
        do_reset();
        activate_mask = 8'b0000_0011; activate_color = 2'd1; tick(); idle_inputs();
        checks++; if ({ok_left, ok_right} !== 2'b01)
            $display("FAIL mv_edge_ok got %b exp 01", {ok_left, ok_right}); else passed++;
        move_right = 1; tick(); idle_inputs();
        checks++; if (active !== 8'b0000_0110) $display("FAIL mv_right got %b exp 00000110", active); else passed++;
        checks++; if (color[5:2] !== 4'b0101) $display("FAIL mv_right_col got %b exp 0101", color[5:2]); else passed++;
        move_left = 1; tick(); idle_inputs();
        checks++; if (active !== 8'b0000_0011) $display("FAIL mv_left got %b exp 00000011", active); else passed++;
        off_mask = 8'b0000_0001; tick(); idle_inputs();
        checks++; if (active !== 8'b0000_0010) $display("FAIL off_mask got %b exp 00000010", active); else passed++;
        // move_down: cell 1 has no active cell above and must turn off
        above_active = 8'b0010_0100;
        above_color  = 16'h0830;
        move_down = 1; tick(); idle_inputs();
        checks++; if (active !== 8'b0010_0100) $display("FAIL mv_down got %b exp 00100100", active); else passed++;
        checks++; if ({color[11:10], color[5:4]} !== 4'b1011)
            $display("FAIL mv_down_col got %b exp 1011", {color[11:10], color[5:4]}); else passed++;
    endtask

    task automatic test_landing();
        do_reset();
        activate_mask = 8'b0000_1000; activate_color = 2'd3; tick(); idle_inputs();
        below_fixed = 8'b0000_1000; grav = 1; #1;
        checks++; if (landed !== 1'b1) $display("FAIL land_landed got %b exp 1", landed); else passed++;
        checks++; if (ok_down !== 1'b0) $display("FAIL land_okdown got %b exp 0", ok_down); else passed++;
        grav = 0; #1;
        checks++; if (landed !== 1'b0) $display("FAIL land_noreq got %b exp 0", landed); else passed++;
        idle_inputs();
        fix = 1; tick(); idle_inputs();
        checks++; if (fixed !== 8'b0000_1000) $display("FAIL fix_fixed got %b exp 00001000", fixed); else passed++;
        checks++; if (active !== 8'h00) $display("FAIL fix_active got %b exp 0", active); else passed++;
        checks++; if (color !== 16'h00C0) $display("FAIL fix_color got %h exp 00c0", color); else passed++;
    endtask

    task automatic test_flash();
        do_reset();
        fill_row();
        checks++; if (disp_fixed !== 8'hFF) $display("FAIL fl_full got %h exp ff", disp_fixed); else passed++;
        tick();
        grav_tick();
        checks++; if (disp_fixed !== 8'h00) $display("FAIL fl_g1 got %h exp 00", disp_fixed); else passed++;
        checks++; if (clear_req !== 1'b0) $display("FAIL fl_g1_clr got %b exp 0", clear_req); else passed++;
        grav_tick();
        checks++; if (disp_fixed !== 8'hFF) $display("FAIL fl_g2 got %h exp ff", disp_fixed); else passed++;
        checks++; if (clear_req !== 1'b0) $display("FAIL fl_g2_clr got %b exp 0", clear_req); else passed++;
        grav_tick();
        checks++; if (clear_req !== 1'b1) $display("FAIL fl_g3_clr got %b exp 1", clear_req); else passed++;
        checks++; if (disp_fixed !== 8'hFF) $display("FAIL fl_wait_disp got %h exp ff", disp_fixed); else passed++;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (clear_req !== 1'b1) $display("FAIL fl_hold%0d got %b exp 1", k, clear_req); else passed++;
        end
    endtask

    task automatic test_destruct();
        // Row is in WAIT here; destruct coincides with fix and grav and must win.
        above_fixed = 8'b1010_0000; above_color = 16'h5555;
        destruct = 1; fix = 1; grav = 1; tick(); idle_inputs();
        checks++; if (fixed !== 8'b1010_0000) $display("FAIL ds_fixed got %b exp 10100000", fixed); else passed++;
        checks++; if (active !== 8'h00) $display("FAIL ds_active got %b exp 0", active); else passed++;
        checks++; if (color !== 16'h4400) $display("FAIL ds_color got %h exp 4400", color); else passed++;
        checks++; if (clear_req !== 1'b0) $display("FAIL ds_clr got %b exp 0", clear_req); else passed++;
        grav_tick(); grav_tick();
        checks++; if (disp_fixed !== 8'b1010_0000) $display("FAIL ds_normal got %b exp 10100000", disp_fixed); else passed++;
    endtask

    task automatic test_reset_flash();
        do_reset();
        fill_row(); tick(); grav_tick();
        checks++; if (disp_fixed !== 8'h00) $display("FAIL rf_flash got %h exp 00", disp_fixed); else passed++;
        reset = 1; tick(); reset = 0;
        checks++; if ({active, fixed, disp_fixed} !== 24'h0) $display("FAIL rf_state got %h exp 0", {active, fixed, disp_fixed}); else passed++;
        checks++; if ({color, clear_req, landed} !== 18'h0) $display("FAIL rf_misc got %h exp 0", {color, clear_req, landed}); else passed++;
        checks++; if ({ok_down, ok_left, ok_right} !== 3'b111)
            $display("FAIL rf_ok got %b exp 111", {ok_down, ok_left, ok_right}); else passed++;
        fill_row(); tick(); grav_tick(); grav_tick();
        checks++; if (clear_req !== 1'b0) $display("FAIL rf_restart got %b exp 0", clear_req); else passed++;
        grav_tick();
        checks++; if (clear_req !== 1'b1) $display("FAIL rf_third got %b exp 1", clear_req); else passed++;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_activate();
        test_obstruction();
        test_moves();
        test_landing();
        test_flash();
        test_destruct();
        test_reset_flash();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tetris_row_driver.md
# tetris_row_driver

Drives one full playfield row of WIDTH LED cells. Each cell is off, active (falling piece) or fixed (landed), and carries a COLOR_W-bit colour code. The row performs piece movement and landing checks against its neighbours above and below. It detects a completed row, runs a flash sequence and requests a clear. On destruct it shifts the row above down into itself. The playfield stacks one instance per row under the tetrimino controller; the bottom row ties `below_fixed` to all ones.

## Interface
Parameters:
- WIDTH, 8, cells per row; index 0 = leftmost.
- COLOR_W, 2, colour code bits per cell.
- FLASH_TICKS, 3, gravity ticks a full row flashes before requesting a clear (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- grav  in  1  gravity tick, one-cycle pulse.
- down_req, left_req, right_req  in  1 each  player requests (same cycle as controller check).
- move_down, move_left, move_right  in  1 each  controller-approved moves, one-hot or zero.
- activate_mask  in  WIDTH  cells to make active this cycle (new piece / rotation).
- activate_color  in  COLOR_W  colour for activated cells.
- off_mask  in  WIDTH  active cells to turn off (rotation).
- fix  in  1  convert all active cells to fixed.
- destruct  in  1  shift row above into this row.
- above_active, above_fixed  in  WIDTH each  states of row above.
- above_color  in  WIDTH*COLOR_W  colours of row above; cell i at bits [i*COLOR_W +: COLOR_W].
- below_fixed  in  WIDTH  fixed mask of row below.
- active, fixed  out  WIDTH each  cell states (unmasked, for neighbour rows).
- color  out  WIDTH*COLOR_W  per-cell colour.
- disp_fixed  out  WIDTH  fixed mask gated by flash phase, for the LED matrix.
- ok_down, ok_left, ok_right  out  1 each  no obstruction for this row's active cells.
- landed  out  1  active cell resting on fixed cell while down/grav requested.
- clear_req  out  1  row complete and flash done; held until destruct.

## Operation
- Per-cell next state, priority high→low: destruct, fix, activate, off, move.
  - destruct: cell ← FIXED with above_color[i] if above_fixed[i], else OFF. Active cells in this row are discarded.
  - fix: ACTIVE → FIXED, colour kept.
  - activate_mask[i] on an OFF cell: → ACTIVE with activate_color.
  - off_mask[i] on an ACTIVE cell without activate_mask[i]: → OFF.
  - move_down: cell ← ACTIVE iff above_active[i] (colour from above); an ACTIVE cell whose above is not active → OFF. FIXED cells are unchanged.
  - move_right: cell i ← ACTIVE iff cell i-1 is ACTIVE (colour from i-1); cell 0 ← OFF if ACTIVE.
  - move_left: mirror of move_right, sourcing from i+1.
- Obstruction checks, combinational, over ACTIVE cells only:
  - ok_down = no active i with below_fixed[i].
  - ok_left = no active i with i==0 or fixed[i-1].
  - ok_right = no active i with i==WIDTH-1 or fixed[i+1].
  - With no active cells, all three = 1.
- landed = (grav | down_req) & any(active & below_fixed).
- Row FSM:
  - NORMAL: when fixed == all ones → FLASH; cnt ← 0, phase ← 0.
  - FLASH: each grav toggles phase and increments cnt. disp_fixed = phase ? 0 : fixed. When cnt reaches FLASH_TICKS on a grav → WAIT.
  - WAIT: clear_req = 1, disp_fixed = fixed.
  - destruct in any state → NORMAL, cnt 0, phase 0, clear_req 0.
- In FLASH and WAIT the row ignores activate, off and move. Controller must not drive them.

## Timing
- Reset: all cells OFF, colours 0; active/fixed/disp_fixed/color = 0; FSM NORMAL; cnt 0; clear_req 0; ok_* = 1; landed = 0.
- Cell state changes are visible one cycle after the command.
- ok_*, landed and disp_fixed are combinational from current state and inputs, with zero latency.
- FLASH is entered the cycle after the row becomes full.
- clear_req rises the cycle after the FLASH_TICKS-th grav in FLASH.
- destruct and fix in the same cycle: destruct wins.
- reset mid-FLASH or mid-WAIT returns to NORMAL next cycle.
- grav coincident with destruct: destruct only.

## Test plan
- Reset, then activate_mask=8'b0001_1000, color=2 → next cycle active=8'b0001_1000, color fields 3/4 = 2, ok_left=ok_right=ok_down=1.
- Active 8'b1000_0000 with fixed 8'b0100_0000 → ok_right=0, ok_left=0. Apply move_right with active 8'b0000_0011 → next cycle active=8'b0000_0110.
- below_fixed=8'b0000_1000, active=8'b0000_1000, grav=1 → landed=1, ok_down=0. fix → fixed=8'b0000_1000, active=0.
- Fill row to all fixed with FLASH_TICKS=3 → FLASH next cycle. disp_fixed alternates 0/FF per grav. clear_req=1 after third grav and holds across 10 idle cycles.
- destruct with above_fixed=8'b1010_0000, above colours 1 → fixed=8'b1010_0000, those colours 1, clear_req=0, FSM NORMAL.
- Assert reset during FLASH → next cycle all outputs at reset values. Subsequent full row restarts flash count from 0.
